// File: rtl/snowf_pkg.sv
// Shared types and constants for the collectible snowflake controller and
// the reusable bob generator.
package snowf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_COLLECT = 3'd3,
    ST_GONE    = 3'd4
  } snowf_state_e;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam logic [1:0] FRM_IDLE       = 2'd0;
  localparam logic [1:0] FRM_SPARK_BASE = 2'd1;
  localparam logic [1:0] FRM_SPARK_CNT  = 2'd3;

  // Sparkle frames run BASE .. BASE+CNT-1 and wrap back to BASE.
  function automatic logic [1:0] next_spark(input logic [1:0] frm);
    if (frm == FRM_SPARK_BASE + FRM_SPARK_CNT - 2'd1) begin
      return FRM_SPARK_BASE;
    end
    return frm + 2'd1;
  endfunction

endpackage

// File: rtl/snowf_bob_gen.sv
// Bob generator for animated pickups: a frame-tick divider driving a
// triangle offset 0 -> BOB_AMP -> 0 that repeats.
module snowf_bob_gen #(
  parameter int BOB_AMP = 3,
  parameter int BOB_DIV = 4,
  parameter int OFF_W   = $clog2(BOB_AMP + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             frame_tick,
  output logic [OFF_W-1:0] offset
);

  localparam int               DIV_W    = (BOB_DIV > 1) ? $clog2(BOB_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BOB_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);
  localparam logic [OFF_W-1:0] AMP_M1   = OFF_W'(BOB_AMP - 1);

  logic [DIV_W-1:0] div_q;
  logic [OFF_W-1:0] off_q;
  logic             up_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      off_q <= '0;
      up_q  <= 1'b1;
    end else if (clr) begin
      div_q <= '0;
      off_q <= '0;
      up_q  <= 1'b1;
    end else if (frame_tick) begin
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        // Direction flips on the step that lands on a peak or on zero.
        if (up_q) begin
          off_q <= off_q + OFF_ONE;
          if (off_q == AMP_M1) up_q <= 1'b0;
        end else begin
          off_q <= off_q - OFF_ONE;
          if (off_q == OFF_ONE) up_q <= 1'b1;
        end
      end else begin
        div_q <= div_q + DIV_ONE;
      end
    end
  end

  assign offset = off_q;

endmodule

// File: rtl/snowf_item_ctrl.sv
// One collectible snowflake: spawn, bob, sparkle on pickup, then hide.
// Define SNOWF_RESPAWN_EN to respawn the flake RESPAWN_TICKS frames after it disappears.
module snowf_item_ctrl
  import snowf_pkg::*;
#(
  parameter logic [X_W-1:0] X0            = 10'd300,
  parameter logic [Y_W-1:0] Y0            = 9'd200,
  parameter int             BOB_AMP       = 3,
  parameter int             BOB_DIV       = 4,
  parameter int             COLLECT_TICKS = 8,
  parameter int             RESPAWN_TICKS = 120
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           frame_tick,
  input  logic           level_start,
  input  logic           snowf_get,
  output logic           det_clr,
  output logic [X_W-1:0] x_snowf,
  output logic [Y_W-1:0] y_snowf,
  output logic           snowf_vis,
  output logic [1:0]     anim_frame,
  output logic           collect_pulse,
  output logic [2:0]     state_dbg
);

  if (BOB_AMP < 1 || BOB_AMP > 7 || BOB_DIV < 1 || COLLECT_TICKS < 1 ||
      RESPAWN_TICKS < 1 || int'(Y0) < BOB_AMP) begin : g_bad_params
    $error("snowf_item_ctrl: parameter out of range");
  end

  localparam int            OFF_W   = $clog2(BOB_AMP + 1);
  localparam int            CT_W    = $clog2(COLLECT_TICKS + 1);
  localparam logic [CT_W-1:0] CT_LAST = CT_W'(COLLECT_TICKS - 1);
  localparam logic [CT_W-1:0] CT_ONE  = CT_W'(1);

  snowf_state_e     state_q;
  logic             det_clr_q;
  logic             vis_q;
  logic [1:0]       anim_q;
  logic             pulse_q;
  logic [CT_W-1:0]  col_cnt_q;

  logic             resp_done;
  logic             go_arm;
  logic             bob_clr;
  logic             bob_tick;
  logic [OFF_W-1:0] bob_off;

`ifdef SNOWF_RESPAWN_EN
  localparam int              RT_W    = $clog2(RESPAWN_TICKS + 1);
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(RESPAWN_TICKS - 1);
  localparam logic [RT_W-1:0] RT_ONE  = RT_W'(1);

  logic [RT_W-1:0] resp_cnt_q;

  assign resp_done = (state_q == ST_GONE) && frame_tick && (resp_cnt_q == RT_LAST);
`else
  assign resp_done = 1'b0;
`endif

  // Entering ARM (by level start or respawn) resets the bob phase so the
  // flake always reappears at Y0.
  assign go_arm   = level_start | resp_done;
  assign bob_clr  = go_arm | (state_q == ST_ARM);
  assign bob_tick = frame_tick & (state_q == ST_ACTIVE) & ~snowf_get & ~level_start;

  snowf_bob_gen #(
    .BOB_AMP (BOB_AMP),
    .BOB_DIV (BOB_DIV),
    .OFF_W   (OFF_W)
  ) u_bob (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (bob_clr),
    .frame_tick (bob_tick),
    .offset     (bob_off)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      det_clr_q  <= 1'b1;
      vis_q      <= 1'b0;
      anim_q     <= FRM_IDLE;
      pulse_q    <= 1'b0;
      col_cnt_q  <= '0;
`ifdef SNOWF_RESPAWN_EN
      resp_cnt_q <= '0;
`endif
    end else begin
      pulse_q <= 1'b0;
      if (go_arm) begin
        state_q    <= ST_ARM;
        det_clr_q  <= 1'b1;
        vis_q      <= 1'b1;
        anim_q     <= FRM_IDLE;
        col_cnt_q  <= '0;
`ifdef SNOWF_RESPAWN_EN
        resp_cnt_q <= '0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
          end
          ST_ARM: begin
            state_q   <= ST_ACTIVE;
            det_clr_q <= 1'b0;
          end
          ST_ACTIVE: begin
            if (snowf_get) begin
              state_q   <= ST_COLLECT;
              det_clr_q <= 1'b1;
              pulse_q   <= 1'b1;
              anim_q    <= FRM_SPARK_BASE;
              col_cnt_q <= '0;
            end
          end
          ST_COLLECT: begin
            if (frame_tick) begin
              if (col_cnt_q == CT_LAST) begin
                state_q    <= ST_GONE;
                vis_q      <= 1'b0;
                anim_q     <= FRM_IDLE;
`ifdef SNOWF_RESPAWN_EN
                resp_cnt_q <= '0;
`endif
              end else begin
                col_cnt_q <= col_cnt_q + CT_ONE;
                anim_q    <= next_spark(anim_q);
              end
            end
          end
          ST_GONE: begin
`ifdef SNOWF_RESPAWN_EN
            if (frame_tick) resp_cnt_q <= resp_cnt_q + RT_ONE;
`endif
          end
          default: begin
            state_q   <= ST_IDLE;
            det_clr_q <= 1'b1;
            vis_q     <= 1'b0;
            anim_q    <= FRM_IDLE;
          end
        endcase
      end
    end
  end

  // The offset is a register and only moves in ACTIVE, so y is frozen
  // everywhere else and snaps back to Y0 whenever ARM clears the generator.
  assign y_snowf       = Y0 - Y_W'(bob_off);
  assign x_snowf       = X0;
  assign det_clr       = det_clr_q;
  assign snowf_vis     = vis_q;
  assign anim_frame    = anim_q;
  assign collect_pulse = pulse_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_snowf_item_ctrl.sv
// Self-checking bench for snowf_item_ctrl: directed scenarios plus random
// stimulus scored against a frame-count based reference model.
module tb_snowf_item_ctrl;

  localparam logic [9:0] X0            = 10'd300;
  localparam logic [8:0] Y0            = 9'd200;
  localparam int         BOB_AMP       = 3;
  localparam int         BOB_DIV       = 4;
  localparam int         COLLECT_TICKS = 8;
  localparam int         RESPAWN_TICKS = 5;

  localparam int P_IDLE    = 0;
  localparam int P_ARM     = 1;
  localparam int P_ACTIVE  = 2;
  localparam int P_COLLECT = 3;
  localparam int P_GONE    = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       level_start = 1'b0;
  logic       snowf_get = 1'b0;
  logic       det_clr;
  logic [9:0] x_snowf;
  logic [8:0] y_snowf;
  logic       snowf_vis;
  logic [1:0] anim_frame;
  logic       collect_pulse;
  logic [2:0] state_dbg;

  snowf_item_ctrl #(
    .X0            (X0),
    .Y0            (Y0),
    .BOB_AMP       (BOB_AMP),
    .BOB_DIV       (BOB_DIV),
    .COLLECT_TICKS (COLLECT_TICKS),
    .RESPAWN_TICKS (RESPAWN_TICKS)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_tick    (frame_tick),
    .level_start   (level_start),
    .snowf_get     (snowf_get),
    .det_clr       (det_clr),
    .x_snowf       (x_snowf),
    .y_snowf       (y_snowf),
    .snowf_vis     (snowf_vis),
    .anim_frame    (anim_frame),
    .collect_pulse (collect_pulse),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [23:0] exp_q[$];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int m_phase, m_bob_ticks, m_col_ticks, m_resp_ticks;
  bit m_pulse;

  function automatic int tri_off(input int steps);
    int p;
    p = steps % (2 * BOB_AMP);
    return (p <= BOB_AMP) ? p : 2 * BOB_AMP - p;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_bob_ticks = 0;
    m_col_ticks = 0;
    m_resp_ticks = 0;
    m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit ls, input bit ft, input bit get);
    m_pulse = 1'b0;
    if (ls) begin
      m_phase = P_ARM;
      m_bob_ticks = 0;
      m_col_ticks = 0;
      m_resp_ticks = 0;
    end else begin
      case (m_phase)
        P_ARM: m_phase = P_ACTIVE;
        P_ACTIVE: begin
          if (get) begin
            m_phase = P_COLLECT;
            m_pulse = 1'b1;
            m_col_ticks = 0;
          end else if (ft) begin
            m_bob_ticks++;
          end
        end
        P_COLLECT: begin
          if (ft) begin
            m_col_ticks++;
            if (m_col_ticks == COLLECT_TICKS) begin
              m_phase = P_GONE;
              m_resp_ticks = 0;
            end
          end
        end
        P_GONE: begin
`ifdef SNOWF_RESPAWN_EN
          if (ft) begin
            m_resp_ticks++;
            if (m_resp_ticks == RESPAWN_TICKS) begin
              m_phase = P_ARM;
              m_bob_ticks = 0;
            end
          end
`endif
        end
        default: begin
        end
      endcase
    end
  endtask

  function automatic logic [23:0] model_expect();
    logic       vis, det;
    logic [1:0] anim;
    logic [8:0] y;
    vis  = (m_phase == P_ARM) || (m_phase == P_ACTIVE) || (m_phase == P_COLLECT);
    det  = (m_phase != P_ACTIVE);
    anim = (m_phase == P_COLLECT) ? 2'(1 + (m_col_ticks % 3)) : 2'd0;
    y    = 9'(int'(Y0) - tri_off(m_bob_ticks / BOB_DIV));
    return {vis, det, anim, m_pulse, y, X0};
  endfunction

  task automatic check_outputs(input string ctx);
    logic [23:0] e;
    if (exp_q.size() == 0) begin
      check_val({ctx, ".exp_q_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check_val({ctx, ".vis"},   int'(snowf_vis),     int'(e[23]));
    check_val({ctx, ".det"},   int'(det_clr),       int'(e[22]));
    check_val({ctx, ".anim"},  int'(anim_frame),    int'(e[21:20]));
    check_val({ctx, ".pulse"}, int'(collect_pulse), int'(e[19]));
    check_val({ctx, ".y"},     int'(y_snowf),       int'(e[18:10]));
    check_val({ctx, ".x"},     int'(x_snowf),       int'(e[9:0]));
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input string ctx, input bit ls, input bit ft, input bit get);
    @(negedge clk);
    level_start = ls;
    frame_tick  = ft;
    snowf_get   = get;
    model_step(ls, ft, get);
    exp_q.push_back(model_expect());
    @(posedge clk);
    #1;
    check_outputs(ctx);
  endtask

  // ---------------- stimulus ----------------
  int y_table[6] = '{199, 198, 197, 198, 199, 200};

  initial begin
    bit get_lvl;

    // Reset values
    reset_n = 1'b0;
    #12;
    model_reset();
    exp_q.push_back(model_expect());
    check_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Start: ARM for one clock, then ACTIVE at Y0
    drive_cycle("arm", 1'b1, 1'b0, 1'b0);
    check_val("arm.det_clr_direct", int'(det_clr), 1);
    drive_cycle("active", 1'b0, 1'b0, 1'b0);
    check_val("active.y_direct", int'(y_snowf), 200);
    check_val("active.det_direct", int'(det_clr), 0);

    // Bob: 24 frame ticks, y steps every 4 ticks
    for (int i = 0; i < 24; i++) begin
      drive_cycle("bob", 1'b0, 1'b1, 1'b0);
      drive_cycle("bob_gap", 1'b0, 1'b0, 1'b0);
      if ((i % 4) == 3) check_val("bob.y_table", int'(y_snowf), y_table[i / 4]);
    end

    // Pickup with snowf_get held high, then sparkle and disappear
    drive_cycle("pickup", 1'b0, 1'b0, 1'b1);
    check_val("pickup.pulse_direct", int'(collect_pulse), 1);
    drive_cycle("pickup_hold", 1'b0, 1'b0, 1'b1);
    check_val("pickup.pulse_once", int'(collect_pulse), 0);
    for (int i = 0; i < COLLECT_TICKS; i++) begin
      drive_cycle("sparkle", 1'b0, 1'b1, 1'b1);
      drive_cycle("sparkle_gap", 1'b0, 1'b0, 1'b1);
    end
    check_val("gone.vis_direct", int'(snowf_vis), 0);

    // Hidden period: respawns only when the feature is built
    for (int i = 0; i < 200; i++) begin
      drive_cycle("gone", 1'b0, 1'b1, 1'b0);
      drive_cycle("gone_gap", 1'b0, 1'b0, 1'b0);
      if (i == 4) begin
`ifdef SNOWF_RESPAWN_EN
        check_val("respawn.vis", int'(snowf_vis), 1);
        check_val("respawn.y", int'(y_snowf), 200);
`else
        check_val("no_respawn.vis_early", int'(snowf_vis), 0);
`endif
      end
    end
`ifndef SNOWF_RESPAWN_EN
    check_val("no_respawn.vis_200", int'(snowf_vis), 0);
`endif

    // Sticky snowf_get through level_start: pulse only after ARM
    drive_cycle("sticky_ls", 1'b1, 1'b0, 1'b1);
    check_val("sticky.arm_no_pulse", int'(collect_pulse), 0);
    drive_cycle("sticky_arm", 1'b0, 1'b0, 1'b1);
    check_val("sticky.arm_exit_no_pulse", int'(collect_pulse), 0);
    drive_cycle("sticky_act", 1'b0, 1'b0, 1'b1);
    check_val("sticky.first_active_pulse", int'(collect_pulse), 1);

    // level_start and snowf_get in the same ACTIVE cycle
    drive_cycle("same_ls", 1'b1, 1'b0, 1'b0);
    drive_cycle("same_arm", 1'b0, 1'b0, 1'b0);
    drive_cycle("same_both", 1'b1, 1'b1, 1'b1);
    check_val("same.no_pulse", int'(collect_pulse), 0);

    // Random traffic
    get_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      bit ls, ft;
      ls = ($urandom_range(0, 79) == 0);
      ft = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 11) == 0) get_lvl = ~get_lvl;
      drive_cycle("rand", ls, ft, get_lvl);
    end

    // Asynchronous reset in the middle of COLLECT
    drive_cycle("ar_ls", 1'b1, 1'b0, 1'b0);
    drive_cycle("ar_arm", 1'b0, 1'b0, 1'b0);
    drive_cycle("ar_get", 1'b0, 1'b0, 1'b1);
    drive_cycle("ar_tick", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    level_start = 1'b0;
    frame_tick  = 1'b0;
    snowf_get   = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_expect());
    check_outputs("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    drive_cycle("post_rst_idle", 1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
